// File: rtl/sd_pkg.sv
// Shared constants for the SD CMD-line engine: register map, STATUS bit
// positions, FSM state encoding and the CRC7 generator polynomial.
package sd_pkg;

  localparam logic [1:0] ADDR_ARG    = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESP   = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_CRC_ERR = 3;
  localparam int ST_IDX_LSB = 8;

  // x^7 + x^3 + 1 with the x^7 term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_TURN,
    S_WAIT,
    S_RECV,
    S_FIN
  } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial MSB-first CRC7 shared by the transmit and receive paths.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// Avalon-MM SD CMD-line engine: generates SD_CLK, sends a 48-bit command
// frame with CRC7 and optionally captures and checks a 48-bit response.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NCR_MAX    = 64,
  parameter int TURNAROUND = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  inout  wire         sd_cmd,
  output logic        irq
);

  logic [15:0] r_div;
  logic        r_sdClk;
  logic        w_toggle;
  logic        w_fallTick;
  logic        w_riseTick;

  sd_state_e   r_state;
  logic [31:0] r_arg;
  logic [7:0]  r_cmd;
  logic        r_busy;
  logic        r_done;
  logic        r_timeout;
  logic        r_crcErr;
  logic [31:0] r_resp;
  logic [5:0]  r_rxIdx;
  logic [39:0] r_tx;
  logic [5:0]  r_bitCnt;
  logic [15:0] r_cnt;
  logic [44:0] r_rx;
  logic        r_cmdOut;
  logic        r_cmdOe;

  logic        w_wr;
  logic        w_wrArg;
  logic        w_wrCmd;
  logic        w_wrStat;
  logic        w_cmdIn;
  logic        w_txBit;
  logic [2:0]  w_crcSel;
  logic [45:0] w_rxFrame;
  logic [31:0] w_status;
  logic        w_crcClr;
  logic        w_crcEn;
  logic        w_crcBit;
  logic [6:0]  w_crc;

  assign w_toggle   = (r_div == 16'(CLK_DIV - 1));
  assign w_fallTick = w_toggle & r_sdClk;
  assign w_riseTick = w_toggle & ~r_sdClk;

  assign w_wr     = chipselect & ~write_n;
  assign w_wrArg  = w_wr && (address == ADDR_ARG);
  assign w_wrCmd  = w_wr && (address == ADDR_CMD);
  assign w_wrStat = w_wr && (address == ADDR_STATUS);

  assign sd_cmd  = r_cmdOe ? r_cmdOut : 1'bz;
  assign w_cmdIn = sd_cmd;
  assign sd_clk  = r_sdClk;
  assign irq     = r_done & r_cmd[7];

  // Frame positions 40..46 carry the CRC MSB first, position 47 the end bit
  assign w_crcSel = 3'd6 - r_bitCnt[2:0];
  assign w_txBit  = (r_bitCnt < 6'd40) ? r_tx[39] :
                    (r_bitCnt < 6'd47) ? w_crc[w_crcSel] : 1'b1;

  // Only frame positions 2..47 are kept; start and transmission bits are not stored
  assign w_rxFrame = {r_rx, w_cmdIn};

  assign w_crcClr = ((r_state == S_IDLE) && w_wrCmd) || (r_state == S_TURN);
  assign w_crcEn  = ((r_state == S_SEND) && w_fallTick && (r_bitCnt < 6'd40)) ||
                    ((r_state == S_WAIT) && w_riseTick && !w_cmdIn) ||
                    ((r_state == S_RECV) && w_riseTick && (r_bitCnt < 6'd40));
  assign w_crcBit = (r_state == S_SEND) ? r_tx[39] : w_cmdIn;

  sd_crc7 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_crcClr),
    .i_en    (w_crcEn),
    .i_bit   (w_crcBit),
    .o_crc   (w_crc)
  );

  always_comb begin
    w_status                    = '0;
    w_status[ST_BUSY]           = r_busy;
    w_status[ST_DONE]           = r_done;
    w_status[ST_TIMEOUT]        = r_timeout;
    w_status[ST_CRC_ERR]        = r_crcErr;
    w_status[ST_IDX_LSB +: 6]   = r_rxIdx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div   <= '0;
      r_sdClk <= 1'b1;
    end else if (w_toggle) begin
      r_div   <= '0;
      r_sdClk <= ~r_sdClk;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // STATUS-write clears come first so that flags set by the FSM in the same cycle win
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_arg     <= '0;
      r_cmd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_crcErr  <= 1'b0;
      r_resp    <= '0;
      r_rxIdx   <= '0;
      r_tx      <= '0;
      r_bitCnt  <= '0;
      r_cnt     <= '0;
      r_rx      <= '0;
      r_cmdOut  <= 1'b0;
      r_cmdOe   <= 1'b0;
    end else begin
      if (w_wrStat) begin
        r_done    <= 1'b0;
        r_timeout <= 1'b0;
        r_crcErr  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_wrArg) r_arg <= writedata;
          if (w_wrCmd) begin
            r_cmd     <= writedata[7:0];
            r_tx      <= {2'b01, writedata[5:0], r_arg};
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_crcErr  <= 1'b0;
            r_bitCnt  <= '0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_fallTick) begin
            if (r_bitCnt == 6'd48) begin
              r_cmdOe <= 1'b0;
              r_cnt   <= '0;
              r_state <= r_cmd[6] ? S_TURN : S_FIN;
            end else begin
              r_cmdOe  <= 1'b1;
              r_cmdOut <= w_txBit;
              r_tx     <= {r_tx[38:0], 1'b0};
              r_bitCnt <= r_bitCnt + 6'd1;
            end
          end
        end
        S_TURN: begin
          if (w_riseTick) begin
            if (r_cnt == 16'(TURNAROUND - 1)) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_WAIT: begin
          if (w_riseTick) begin
            if (!w_cmdIn) begin
              r_rx     <= '0;
              r_bitCnt <= 6'd1;
              r_state  <= S_RECV;
            end else if (r_cnt == 16'(NCR_MAX - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= S_FIN;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_RECV: begin
          if (w_riseTick) begin
            if (r_bitCnt == 6'd47) begin
              r_resp   <= w_rxFrame[39:8];
              r_rxIdx  <= w_rxFrame[45:40];
              r_crcErr <= (w_rxFrame[7:1] != w_crc) || !w_rxFrame[0];
              r_state  <= S_FIN;
            end else begin
              r_rx     <= {r_rx[43:0], w_cmdIn};
              r_bitCnt <= r_bitCnt + 6'd1;
            end
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        ADDR_ARG:    readdata <= r_arg;
        ADDR_CMD:    readdata <= {24'd0, r_cmd};
        ADDR_STATUS: readdata <= w_status;
        default:     readdata <= r_resp;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: frame capture at SD_CLK rising edges,
// a simple card responder, timeout, busy-write protection and reset.
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        sd_clk;
  logic        irq;
  wire         sd_cmd;
  logic        cardOe = 1'b0;
  logic        cardBit = 1'b1;

  logic [31:0] readdata1;
  logic        sd_clk1;
  logic        irq1;
  wire         sd_cmd1;

  int          assertCount = 0;
  int          failCount = 0;

  logic [47:0] monShift = '0;
  logic [47:0] monFrame = '0;
  int          monBits = 0;
  int          monCount = 0;

  assign sd_cmd = cardOe ? cardBit : 1'bz;
  pullup (sd_cmd);
  pullup (sd_cmd1);

  always #5 clk = ~clk;

  sd_cmd_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .sd_cmd     (sd_cmd),
    .irq        (irq)
  );

  sd_cmd_engine #(.CLK_DIV(1)) dutDiv1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (1'b0),
    .write_n    (1'b1),
    .writedata  (writedata),
    .readdata   (readdata1),
    .sd_clk     (sd_clk1),
    .sd_cmd     (sd_cmd1),
    .irq        (irq1)
  );

  // Card-side view of the line: every 48-bit frame starting with a 0 bit
  always @(posedge sd_clk or negedge reset_n) begin
    if (!reset_n) begin
      monBits = 0;
    end else begin
      #1;
      if (monBits == 0) begin
        if (sd_cmd == 1'b0) begin
          monShift = '0;
          monBits  = 1;
        end
      end else begin
        monShift = {monShift[46:0], sd_cmd};
        monBits++;
        if (monBits == 48) begin
          monFrame = monShift;
          monCount++;
          monBits  = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address = addr;
    @(negedge clk);
    data = readdata;
  endtask

  task automatic captureFrame(input int c0, input logic [47:0] expected,
                              input string tag);
    for (int n = 0; n < 200 && monCount == c0; n++) begin
      @(posedge sd_clk);
      #2;
    end
    checkOutput({tag, "_seen"}, 64'(monCount - c0), 64'd1);
    checkOutput(tag, {16'd0, monFrame}, {16'd0, expected});
  endtask

  task automatic cardRespond(input logic [47:0] resp);
    repeat (5) @(negedge sd_clk);
    #1;
    cardOe  = 1'b1;
    cardBit = resp[47];
    for (int i = 46; i >= 0; i--) begin
      @(negedge sd_clk);
      #1;
      cardBit = resp[i];
    end
    @(negedge sd_clk);
    #1;
    cardOe = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] s;
    s = 32'd1;
    for (int n = 0; n < 500 && s[0]; n++) readReg(2'd2, s);
    checkOutput({tag, "_idle"}, {63'd0, s[0]}, 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          c0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_readdata", {32'd0, readdata}, 64'd0);
    checkOutput("rst_sdclk", {63'd0, sd_clk}, 64'd1);
    checkOutput("rst_irq", {63'd0, irq}, 64'd0);
    checkOutput("rst_line", {63'd0, sd_cmd}, 64'd1);
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("div1_sdclk", {63'd0, sd_clk1}, (i % 2 == 1) ? 64'd0 : 64'd1);
      if (i == 3) checkOutput("div4_still_high", {63'd0, sd_clk}, 64'd1);
      if (i == 4) checkOutput("div4_first_fall", {63'd0, sd_clk}, 64'd0);
    end
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), rd);
      checkOutput("rst_reg", {32'd0, rd}, 64'd0);
    end

    // CMD0, no response
    $display("[TB] CMD0 without response");
    applyStimulus(2'd0, 32'h0000_0000);
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_0000);
    captureFrame(c0, 48'h4000_0000_0095, "cmd0_frame");
    waitIdle("cmd0");
    readReg(2'd2, rd);
    checkOutput("cmd0_status", {32'd0, rd}, 64'h0002);
    checkOutput("cmd0_line", {63'd0, sd_cmd}, 64'd1);
    checkOutput("cmd0_irq", {63'd0, irq}, 64'd0);

    // CMD8 with a good R7 response
    $display("[TB] CMD8 with response");
    applyStimulus(2'd2, 32'd0);
    applyStimulus(2'd0, 32'h0000_01AA);
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_0048);
    captureFrame(c0, 48'h4800_0001_AA87, "cmd8_frame");
    cardRespond(48'h0800_0001_AA13);
    waitIdle("cmd8");
    readReg(2'd2, rd);
    checkOutput("cmd8_status", {32'd0, rd}, 64'h0802);
    readReg(2'd3, rd);
    checkOutput("cmd8_resp", {32'd0, rd}, 64'h0000_01AA);

    // CMD8 with one corrupted argument bit
    $display("[TB] CMD8 with corrupted response");
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_0048);
    captureFrame(c0, 48'h4800_0001_AA87, "crc_frame");
    cardRespond(48'h0800_0001_AB13);
    waitIdle("crc");
    readReg(2'd2, rd);
    checkOutput("crc_status", {32'd0, rd}, 64'h080A);
    readReg(2'd3, rd);
    checkOutput("crc_resp", {32'd0, rd}, 64'h0000_01AB);

    // No card response: timeout after TURNAROUND+NCR_MAX SD clocks, irq enabled
    $display("[TB] response timeout");
    applyStimulus(2'd2, 32'd0);
    applyStimulus(2'd0, 32'h0000_0000);
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_00C0);
    captureFrame(c0, 48'h4000_0000_0095, "to_frame");
    repeat (65) @(posedge sd_clk);
    #1;
    readReg(2'd2, rd);
    checkOutput("to_still_busy", {32'd0, rd}, 64'h0801);
    checkOutput("to_irq_low", {63'd0, irq}, 64'd0);
    @(posedge sd_clk);
    repeat (4) @(negedge clk);
    readReg(2'd2, rd);
    checkOutput("to_status", {32'd0, rd}, 64'h0806);
    checkOutput("to_irq_high", {63'd0, irq}, 64'd1);
    applyStimulus(2'd2, 32'hFFFF_FFFF);
    checkOutput("to_irq_cleared", {63'd0, irq}, 64'd0);
    readReg(2'd2, rd);
    checkOutput("to_status_cleared", {32'd0, rd}, 64'h0800);

    // Register writes while busy must not disturb the frame in flight
    $display("[TB] writes during SEND");
    applyStimulus(2'd0, 32'h0000_01AA);
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_0008);
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    applyStimulus(2'd1, 32'h0000_007F);
    applyStimulus(2'd2, 32'h0000_0000);
    readReg(2'd2, rd);
    checkOutput("busy_status", {32'd0, rd}, 64'h0801);
    captureFrame(c0, 48'h4800_0001_AA87, "busy_frame");
    waitIdle("busy");
    readReg(2'd0, rd);
    checkOutput("busy_arg", {32'd0, rd}, 64'h0000_01AA);
    readReg(2'd1, rd);
    checkOutput("busy_cmd", {32'd0, rd}, 64'h0000_0008);
    readReg(2'd2, rd);
    checkOutput("busy_done", {32'd0, rd}, 64'h0802);

    // Reset while the DUT is driving a 0 bit
    $display("[TB] reset mid-SEND");
    applyStimulus(2'd0, 32'hDEAD_BEEF);
    applyStimulus(2'd1, 32'h0000_00C5);
    for (int n = 0; n < 50; n++) begin
      @(posedge sd_clk);
      #1;
      if (sd_cmd == 1'b0) break;
    end
    repeat (2) @(negedge sd_clk);
    #2;
    checkOutput("mid_drive0", {63'd0, sd_cmd}, 64'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_released", {63'd0, sd_cmd}, 64'd1);
    checkOutput("mid_sdclk", {63'd0, sd_clk}, 64'd1);
    checkOutput("mid_readdata", {32'd0, readdata}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      readReg(2'(a), rd);
      checkOutput("mid_reg", {32'd0, rd}, 64'd0);
    end
    c0 = monCount;
    applyStimulus(2'd1, 32'h0000_0000);
    captureFrame(c0, 48'h4000_0000_0095, "post_rst_frame");
    waitIdle("post_rst");
    readReg(2'd2, rd);
    checkOutput("post_rst_status", {32'd0, rd}, 64'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
Hardware SD-card CMD-line engine, an Avalon-MM slave that replaces software bit-banging of the CMD pin through the existing single-bit PIO. Software loads a 32-bit argument and command index. The block generates SD_CLK, serialises the 48-bit command frame with CRC7, and optionally captures a 48-bit response with CRC check and timeout. It sits between the Nios bus and the SD socket CMD/CLK pins.

Parameters:
CLK_DIV, 4, system clocks per SD_CLK half-period (>=1); SD_CLK = clk/(2*CLK_DIV)
NCR_MAX, 64, SD_CLK cycles to wait for a response start bit before timeout
TURNAROUND, 2, SD_CLK cycles with the line released between command end bit and response search

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  Avalon chip select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  write data
readdata  out  32  registered read data
sd_clk  out  1  SD card clock
sd_cmd  inout  1  SD CMD line; driven only while sending, Z otherwise
irq  out  1  level, high while DONE is set and IE=1

Behaviour:
- Register map:
  - 0 ARG: R/W, 32 bits.
  - 1 CMD: W starts a transaction. bits[5:0] index, bit6 RESP_EN, bit7 IE. Read returns the last written value in [7:0].
  - 2 STATUS: R. bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bit3 CRC_ERR, bits[13:8] received response index. Write of any value clears DONE, TIMEOUT and CRC_ERR.
  - 3 RESP: R, response bits [39:8] (the response argument field).
- Read path: readdata is registered, 1-cycle latency, updated every clock. Unused bits read 0.
- Reset values: readdata=0, sd_clk=1, sd_cmd=Z, irq=0, all registers 0, FSM=IDLE.
- SD_CLK generation:
  - A divider counter toggles sd_clk every CLK_DIV clocks; the clock is free-running.
  - fall_tick and rise_tick pulse for one clk cycle on the cycle the toggle happens.
  - Drive updates occur on fall_tick; sampling occurs on rise_tick.
- Command frame: {0,1,index[5:0],ARG[31:0],CRC7[6:0],1}. CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits, MSB first.
- FSM states and transitions:
  - IDLE: sd_cmd=Z. A CMD write loads the shift register, sets BUSY and clears DONE, TIMEOUT and CRC_ERR. The first bit is driven at the next fall_tick; go to SEND.
  - SEND: one bit per fall_tick for 48 bits. After the end bit has been held one full SD_CLK, release the line. Go to TURN if RESP_EN=1, else FIN.
  - TURN: count TURNAROUND rise_ticks, then go to WAIT.
  - WAIT: on each rise_tick sample sd_cmd. A 0 means start bit detected; go to RECV. If NCR_MAX rise_ticks pass with no 0, set TIMEOUT and go to FIN.
  - RECV: shift in the remaining 47 bits on rise_tick. Check CRC7 over bits[47:8]; on mismatch or end bit != 1, set CRC_ERR. Latch RESP and the response index. Go to FIN.
  - FIN: clear BUSY, set DONE, go to IDLE (1 cycle).
- Boundary conditions:
  - A CMD or ARG write while BUSY is ignored.
  - A STATUS write while BUSY does not clear BUSY.
  - A simultaneous FIN and STATUS write: DONE is set (FIN wins).
  - reset_n asserted mid-transaction immediately releases sd_cmd, returns to IDLE and clears all state.
  - CLK_DIV=1 must work: sd_clk = clk/2.

Decomposition:
- Package sd_pkg holds:
  - register address constants;
  - STATUS bit positions;
  - the FSM state enum;
  - the CRC7 polynomial constant.
- Sub-module sd_crc7: serial CRC7 with clear, enable and bit-in inputs and a 7-bit output. It is instantiated once and reused for both TX and RX.

Test Plan:
- CMD0, ARG=0, RESP_EN=0 -> 48-bit frame 0x400000000095 on sd_cmd sampled at sd_clk rising edges. Then BUSY=0, DONE=1, line Z.
- CMD8, ARG=0x000001AA, RESP_EN=1, card model returns 0x08000001AA13 after 5 SD_CLK -> frame 0x48000001AA87 sent. RESP=0x000001AA, STATUS index=8, CRC_ERR=0, TIMEOUT=0.
- Same as the CMD8 case but the model flips one response argument bit -> CRC_ERR=1, DONE=1.
- RESP_EN=1 with no card response -> TIMEOUT=1 after TURNAROUND+NCR_MAX SD_CLKs; irq high when IE=1; a STATUS write clears irq.
- CMD and ARG writes during SEND -> the frame in flight is unchanged and the register readback is unchanged.
- reset_n pulsed low mid-SEND -> sd_cmd goes Z within the same cycle; all registers read 0; a new CMD0 completes normally.
